// File: rtl/sha_pkg.sv
// Shared SHA-256 mining constants and scheduler state encoding.
// Imported by the nonce scheduler and the bench.
package sha_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/nonce_scheduler_if.sv
// Core dispatch / completion and result-write bus of the scheduler.
// master = scheduler side, slave = hashing cores and result memory.
interface nonce_scheduler_if #(
    parameter int NUM_CORES = 4
);

    logic [NUM_CORES-1:0]    core_start;
    logic [31:0]             core_nonce;
    logic [NUM_CORES-1:0]    core_done;
    logic [NUM_CORES*32-1:0] core_h0;
    logic                    mem_we;
    logic [15:0]             mem_addr;
    logic [31:0]             mem_write_data;

    modport master (
        output core_start, core_nonce,
        output mem_we, mem_addr, mem_write_data,
        input  core_done, core_h0
    );

    modport slave (
        input  core_start, core_nonce,
        input  mem_we, mem_addr, mem_write_data,
        output core_done, core_h0
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts after the last grant.
// Pointer advances whenever a grant is issued.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic          hit;
    int            idx;

    always_comb begin
        grant = '0;
        sel   = ptr;
        hit   = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!hit && req[idx]) begin
                grant[idx] = 1'b1;
                sel        = IW'(idx);
                hit        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= sel;
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Sweeps job nonces over SHA-256 cores and writes back each H0.
// Optional cycle counter port under NONCE_SCHED_PERF_EN.
module nonce_scheduler
    import sha_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NUM_NONCE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] output_addr,
    output logic        done,
`ifdef NONCE_SCHED_PERF_EN
    output logic [31:0] perf_cycles,
`endif
    nonce_scheduler_if.master bus
);

    state_t state, state_nxt;

    logic [NUM_CORES-1:0] busy;
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] free;
    logic [NUM_CORES-1:0] disp;
    logic [NUM_CORES-1:0] grant;
    logic [NONCE_W-1:0]   next_nonce;
    logic [NONCE_W-1:0]   nonce_q [NUM_CORES];
    logic                 run;
    logic                 more;
    logic                 accept;

    assign run    = (state == RUN);
    assign accept = (state == IDLE) && start;
    assign more   = next_nonce < NONCE_W'(NUM_NONCE);
    assign free   = ~busy;
    // Lowest set bit of the free mask picks the lowest idle core.
    assign disp   = (run && more) ? (free & (~free + 1'b1)) : '0;

    rr_arbiter #(
        .N(NUM_CORES)
    ) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (pending),
        .grant  (grant)
    );

    always_comb begin
        bus.core_start     = disp;
        bus.core_nonce     = (|disp) ? next_nonce : '0;
        bus.mem_we         = |grant;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                bus.mem_addr       = 16'(output_addr + nonce_q[i]);
                bus.mem_write_data = bus.core_h0[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (!more && busy == '0) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A core freed by a write only becomes dispatchable next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            pending    <= '0;
            next_nonce <= '0;
            for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= '0;
        end else begin
            busy    <= (busy | disp) & ~grant;
            pending <= (pending | (bus.core_done & busy)) & ~grant;
            if (accept) begin
                next_nonce <= '0;
            end else if (|disp) begin
                next_nonce <= next_nonce + 1'b1;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (disp[i]) nonce_q[i] <= next_nonce;
            end
        end
    end

`ifdef NONCE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (run) begin
            perf_cycles <= perf_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: 16-nonce and 2-nonce instances with
// behavioural cores; expected writes are queued and popped on mem_we.
module tb_nonce_scheduler;
    import sha_pkg::*;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        start_a, start_b;
    logic [15:0] base_a, base_b;
    logic        done_a, done_b;
`ifdef NONCE_SCHED_PERF_EN
    logic [31:0] perf_a, perf_b;
`endif

    nonce_scheduler_if #(.NUM_CORES(4)) bus_a ();
    nonce_scheduler_if #(.NUM_CORES(4)) bus_b ();

    nonce_scheduler #(.NUM_CORES(4), .NUM_NONCE(16)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_a),
        .output_addr(base_a),
        .done       (done_a),
`ifdef NONCE_SCHED_PERF_EN
        .perf_cycles(perf_a),
`endif
        .bus        (bus_a.master)
    );

    nonce_scheduler #(.NUM_CORES(4), .NUM_NONCE(2)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_b),
        .output_addr(base_b),
        .done       (done_b),
`ifdef NONCE_SCHED_PERF_EN
        .perf_cycles(perf_b),
`endif
        .bus        (bus_b.master)
    );

    int checks = 0;
    int errors = 0;

    wr_t q_a[$];
    wr_t q_b[$];
    int  disp_a, disp_b, wr_a, wr_b, done_ca, done_cb;
    logic [3:0] first_a;

    int          lat  [2][4];
    int          cnt  [2][4];
    logic [31:0] nr   [2][4];
    logic [3:0]  dn   [2];
    logic [127:0] h0v [2];
    logic [3:0]  spur [2];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int w, input logic [3:0] st,
                        input logic [31:0] nn);
        dn[w] = '0;
        for (int c = 0; c < 4; c++) begin
            if (!reset_n) begin
                cnt[w][c] = 0;
            end else begin
                if (cnt[w][c] > 0) begin
                    cnt[w][c]--;
                    if (cnt[w][c] == 0) begin
                        dn[w][c] = 1'b1;
                        h0v[w][c*32 +: 32] = nr[w][c] + 32'h100;
                    end
                end
                if (st[c]) begin
                    cnt[w][c] = lat[w][c];
                    nr[w][c]  = nn;
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int w = 0; w < 2; w++) begin
            h0v[w]  = '0;
            spur[w] = '0;
            for (int c = 0; c < 4; c++) begin
                cnt[w][c] = 0;
                nr[w][c]  = '0;
            end
        end
        bus_a.core_done = '0;
        bus_a.core_h0   = '0;
        bus_b.core_done = '0;
        bus_b.core_h0   = '0;
        forever begin
            @(posedge clk);
            #1;
            tick(0, bus_a.core_start, bus_a.core_nonce);
            tick(1, bus_b.core_start, bus_b.core_nonce);
            bus_a.core_done = dn[0] | spur[0];
            bus_a.core_h0   = h0v[0];
            bus_b.core_done = dn[1] | spur[1];
            bus_b.core_h0   = h0v[1];
            spur[0] = '0;
            spur[1] = '0;
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (bus_a.mem_we) begin
            wr_a++;
            if (q_a.size() == 0) begin
                chk("a_extra_write", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("a_addr", bus_a.mem_addr, e.addr);
                chk("a_data", bus_a.mem_write_data, e.data);
            end
        end
        if (bus_a.core_start != '0) begin
            if (disp_a == 0) first_a = bus_a.core_start;
            chk("a_onehot", $onehot(bus_a.core_start), 1);
            chk("a_nonce", bus_a.core_nonce, disp_a);
            disp_a++;
        end
        if (done_a) done_ca++;
    end

    always @(negedge clk) begin
        wr_t e;
        if (bus_b.mem_we) begin
            wr_b++;
            if (q_b.size() == 0) begin
                chk("b_extra_write", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("b_addr", bus_b.mem_addr, e.addr);
                chk("b_data", bus_b.mem_write_data, e.data);
            end
        end
        if (bus_b.core_start != '0) begin
            chk("b_core", bus_b.core_start, 4'b0001 << disp_b);
            chk("b_nonce", bus_b.core_nonce, disp_b);
            disp_b++;
        end
        if (done_b) done_cb++;
    end

    task automatic zero_a(input string t);
        chk({t, "_ctl"}, {bus_a.mem_we, done_a, bus_a.core_start}, 0);
        chk({t, "_nonce"}, bus_a.core_nonce, 0);
        chk({t, "_addr"}, bus_a.mem_addr, 0);
        chk({t, "_data"}, bus_a.mem_write_data, 0);
    endtask

    task automatic run_a(input logic [15:0] base, input int poke);
        int cyc;
        int w0;
        int d0;
        bit ok;
        base_a = base;
        disp_a = 0;
        w0 = wr_a;
        d0 = done_ca;
        for (int n = 0; n < 16; n++) begin
            q_a.push_back('{addr: 16'(base + n), data: 32'(n + 'h100)});
        end
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_a) begin
                ok = 1'b1;
                break;
            end
            cyc++;
            start_a = (poke != 0) && (cyc == poke);
        end
        start_a = 1'b0;
        chk("a_finish", ok, 1);
        chk("a_writes", wr_a - w0, 16);
        chk("a_first_core", first_a, 4'b0001);
`ifdef NONCE_SCHED_PERF_EN
        chk("a_perf", perf_a, cyc);
`endif
        repeat (4) @(negedge clk);
        chk("a_done_pulses", done_ca - d0, 1);
        chk("a_q_left", q_a.size(), 0);
`ifdef NONCE_SCHED_PERF_EN
        chk("a_perf_hold", perf_a, cyc);
`endif
    endtask

    initial begin
        int  cyc;
        bit  ok;
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        base_a  = 16'h0;
        base_b  = 16'h0;
        disp_a  = 0;
        disp_b  = 0;
        wr_a    = 0;
        wr_b    = 0;
        done_ca = 0;
        done_cb = 0;
        first_a = '0;
        for (int c = 0; c < 4; c++) begin
            lat[0][c] = 10;
            lat[1][c] = 10;
        end
        repeat (3) @(posedge clk);
        #1 zero_a("rst_a");
        chk("rst_b_ctl", {bus_b.mem_we, done_b, bus_b.core_start}, 0);
        chk("rst_b_bus", {bus_b.mem_addr, bus_b.mem_write_data}, 0);
`ifdef NONCE_SCHED_PERF_EN
        chk("rst_perf", perf_a, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        run_a(16'h1000, 0);

        lat[0][2] = 9;
        run_a(16'hfff8, 20);
        lat[0][2] = 10;

        disp_a = 0;
        q_a.delete();
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (disp_a >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_three_busy", ok, 1);
        #2 reset_n = 1'b0;
        #1 zero_a("mid_rst");
        repeat (2) @(posedge clk);
        #1 zero_a("mid_rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        run_a(16'h2000, 0);

        base_b = 16'h0040;
        disp_b = 0;
        q_b.push_back('{addr: 16'h0040, data: 32'h100});
        q_b.push_back('{addr: 16'h0041, data: 32'h101});
        @(negedge clk);
        spur[1] = 4'b0100;
        repeat (4) @(negedge clk);
        chk("b_idle_spur", wr_b, 0);
        @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done_b) begin
                ok = 1'b1;
                break;
            end
            cyc++;
            if (cyc == 3) spur[1] = 4'b1000;
        end
        chk("b_finish", ok, 1);
        chk("b_writes", wr_b, 2);
        chk("b_dispatches", disp_b, 2);
`ifdef NONCE_SCHED_PERF_EN
        chk("b_perf", perf_b, cyc);
`endif
        spur[1] = 4'b0001;
        repeat (5) @(negedge clk);
        chk("b_post_spur", wr_b, 2);
        chk("b_done_pulses", done_cb, 1);
        chk("b_q_left", q_b.size(), 0);

        cyc = wr_a;
        spur[0] = 4'b0010;
        repeat (5) @(negedge clk);
        chk("a_idle_spur", wr_a - cyc, 0);
        chk("a_idle_start", disp_a, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
